// File: rtl/vector_uop_sequencer_if.sv
// Handshake bundle between an instruction source / micro-op consumer and the
// vector micro-op sequencer.
interface vector_uop_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_vl;
  logic [31:0] in_vstart;
  logic [1:0]  in_sew;
  logic        uop_valid;
  logic        uop_ready;
  logic [31:0] uop_offset;
  logic [3:0]  uop_vl;
  logic        uop_first;
  logic        uop_last;
  logic        flush;
  logic        busy;
  logic        done;

  modport master (
    output in_valid, in_vl, in_vstart, in_sew, uop_ready, flush,
    input  in_ready, uop_valid, uop_offset, uop_vl, uop_first, uop_last, busy, done
  );

  modport slave (
    input  in_valid, in_vl, in_vstart, in_sew, uop_ready, flush,
    output in_ready, uop_valid, uop_offset, uop_vl, uop_first, uop_last, busy, done
  );
endinterface

// File: rtl/vector_uop_sequencer.sv
// Splits one vector instruction (vl, vstart, sew) into datapath-wide micro-ops,
// one per cycle while the consumer is ready.
module vector_uop_sequencer #(
  parameter int unsigned DP_BYTES = 8
) (
  input  logic                   CLK,
  input  logic                   nRST,
  vector_uop_sequencer_if.slave  bus
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t      state, state_nxt;
  logic [31:0] offset, vl_q;
  logic [1:0]  sew_q;
  logic        first_q, done_q, done_nxt;
  logic [31:0] epu, remain, cur_vl;
  logic        accept, fire, last_c, issuing;

  // sew 11 is treated as 32-bit elements
  always_comb begin
    case (sew_q)
      2'b00:   epu = 32'(DP_BYTES);
      2'b01:   epu = 32'(DP_BYTES) >> 1;
      default: epu = 32'(DP_BYTES) >> 2;
    endcase
  end

  assign remain  = vl_q - offset;
  assign cur_vl  = (remain < epu) ? remain : epu;
  assign last_c  = (offset + cur_vl) >= vl_q;
  assign issuing = (state == ISSUE);

  assign bus.in_ready   = (state == IDLE) && !bus.flush;
  assign bus.uop_valid  = issuing;
  assign bus.uop_offset = offset;
  assign bus.uop_vl     = issuing ? cur_vl[3:0] : 4'd0;
  assign bus.uop_first  = issuing && first_q;
  assign bus.uop_last   = issuing && last_c;
  assign bus.busy       = issuing;
  assign bus.done       = done_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign fire   = issuing && bus.uop_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // flush wins over both acceptance and an in-flight handshake
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (bus.in_vstart < bus.in_vl) state_nxt = ISSUE;
          else                           done_nxt  = 1'b1;
        end
        ISSUE: if (fire && last_c) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      offset  <= '0;
      vl_q    <= '0;
      sew_q   <= '0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= done_nxt;
      if (accept) begin
        vl_q    <= bus.in_vl;
        sew_q   <= bus.in_sew;
        offset  <= bus.in_vstart;
        first_q <= 1'b1;
      end else if (fire && !bus.flush) begin
        offset  <= offset + cur_vl;
        first_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vector_uop_sequencer.sv
// Directed, table-driven bench for vector_uop_sequencer (DP_BYTES=8).
module tb_vector_uop_sequencer;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  vector_uop_sequencer_if bus();

  vector_uop_sequencer #(.DP_BYTES(8)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [31:0] vl;
    logic [31:0] vstart;
    logic [1:0]  sew;
    bit          start;
    logic [31:0] off;
    logic [3:0]  uvl;
    bit          first;
    bit          last;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_uop(input string name, input logic [31:0] off, input logic [3:0] uvl,
                         input bit first, input bit last);
    chk(name, {25'd0, bus.uop_valid, bus.uop_offset, bus.uop_vl, bus.uop_first, bus.uop_last},
              {25'd0, 1'b1, off, uvl, first, last});
  endtask

  // called at a negedge; returns at the negedge after the accepting posedge
  task automatic send(input logic [31:0] vl, input logic [31:0] vs, input logic [1:0] sew);
    bus.in_valid  = 1'b1;
    bus.in_vl     = vl;
    bus.in_vstart = vs;
    bus.in_sew    = sew;
    @(negedge clk);
    bus.in_valid  = 1'b0;
  endtask

  initial begin
    tbl.push_back('{32'd10, 32'd0, 2'd2, 1, 32'd0,  4'd2, 1, 0});
    tbl.push_back('{32'd10, 32'd0, 2'd2, 0, 32'd2,  4'd2, 0, 0});
    tbl.push_back('{32'd10, 32'd0, 2'd2, 0, 32'd4,  4'd2, 0, 0});
    tbl.push_back('{32'd10, 32'd0, 2'd2, 0, 32'd6,  4'd2, 0, 0});
    tbl.push_back('{32'd10, 32'd0, 2'd2, 0, 32'd8,  4'd2, 0, 1});
    tbl.push_back('{32'd13, 32'd3, 2'd0, 1, 32'd3,  4'd8, 1, 0});
    tbl.push_back('{32'd13, 32'd3, 2'd0, 0, 32'd11, 4'd2, 0, 1});
    tbl.push_back('{32'd6,  32'd0, 2'd1, 1, 32'd0,  4'd4, 1, 0});
    tbl.push_back('{32'd6,  32'd0, 2'd1, 0, 32'd4,  4'd2, 0, 1});
    tbl.push_back('{32'd5,  32'd1, 2'd3, 1, 32'd1,  4'd2, 1, 0});
    tbl.push_back('{32'd5,  32'd1, 2'd3, 0, 32'd3,  4'd2, 0, 1});
    tbl.push_back('{32'd3,  32'd0, 2'd0, 1, 32'd0,  4'd3, 1, 1});

    nrst = 1'b0;
    bus.in_valid = 1'b0; bus.in_vl = '0; bus.in_vstart = '0; bus.in_sew = '0;
    bus.uop_ready = 1'b1; bus.flush = 1'b0;
    #1;
    chk("reset_outs", {bus.uop_valid, bus.uop_vl, bus.uop_first, bus.uop_last, bus.busy, bus.done}, '0);
    chk("reset_offset", bus.uop_offset, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    #1 chk("in_ready_after_reset", bus.in_ready, 1);
    @(negedge clk);

    // table: back-to-back instructions at full throughput
    foreach (tbl[i]) begin
      if (tbl[i].start) send(tbl[i].vl, tbl[i].vstart, tbl[i].sew);
      chk_uop($sformatf("tbl%0d", i), tbl[i].off, tbl[i].uvl, tbl[i].first, tbl[i].last);
      @(negedge clk);
      if (tbl[i].last) begin
        chk($sformatf("tbl%0d_done", i), {bus.done, bus.busy, bus.uop_valid}, 3'b100);
        @(negedge clk);
        chk($sformatf("tbl%0d_done_pulse", i), bus.done, 0);
      end
    end

    // vstart == vl: empty instruction
    send(32'd8, 32'd8, 2'd2);
    chk("empty_done", {bus.done, bus.busy, bus.uop_valid, bus.uop_vl}, {3'b100, 4'd0});
    @(negedge clk);
    chk("empty_after", {bus.done, bus.busy, bus.uop_valid}, 3'b000);

    // stall on uop0 for 3 cycles
    bus.uop_ready = 1'b0;
    send(32'd6, 32'd0, 2'd1);
    for (int k = 0; k < 3; k++) begin
      chk_uop($sformatf("stall%0d", k), 32'd0, 4'd4, 1, 0);
      if (k == 2) bus.uop_ready = 1'b1;
      @(negedge clk);
    end
    chk_uop("stall_uop1", 32'd4, 4'd2, 0, 1);
    @(negedge clk);
    chk("stall_done", bus.done, 1);
    @(negedge clk);

    // flush on uop1, then restart at vstart=2
    send(32'd10, 32'd0, 2'd2);
    chk_uop("fl_uop0", 32'd0, 4'd2, 1, 0);
    @(negedge clk);
    chk_uop("fl_uop1", 32'd2, 4'd2, 0, 0);
    bus.flush = 1'b1;
    #1 chk("fl_in_ready", bus.in_ready, 0);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("fl_idle", {bus.uop_valid, bus.busy, bus.done, bus.uop_vl}, '0);
    @(negedge clk);
    chk("fl_no_done", bus.done, 0);
    send(32'd10, 32'd2, 2'd2);
    for (int k = 0; k < 4; k++) begin
      chk_uop($sformatf("rs%0d", k), 32'(2 + 2 * k), 4'd2, k == 0, k == 3);
      @(negedge clk);
    end
    chk("rs_done", bus.done, 1);
    @(negedge clk);

    // flush in IDLE blocks acceptance
    bus.flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_vl = 32'd4; bus.in_vstart = 32'd0; bus.in_sew = 2'd0;
    #1 chk("fl_idle_ready", bus.in_ready, 0);
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("fl_idle_noacc", {bus.uop_valid, bus.busy, bus.done}, 3'b000);
    @(negedge clk);

    // reset mid-instruction
    send(32'd10, 32'd0, 2'd2);
    @(negedge clk);
    chk_uop("rst_pre", 32'd2, 4'd2, 0, 0);
    nrst = 1'b0;
    #1 chk("rst_mid", {bus.uop_valid, bus.uop_vl, bus.uop_first, bus.uop_last, bus.busy, bus.done}, '0);
    chk("rst_mid_off", bus.uop_offset, 0);
    @(negedge clk);
    nrst = 1'b1;
    #1 chk("rst_rel_ready", bus.in_ready, 1);
    @(negedge clk);
    chk("rst_no_done0", {bus.done, bus.busy}, 2'b00);
    @(negedge clk);
    chk("rst_no_done1", {bus.done, bus.busy}, 2'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
